// File: rtl/iru_pkg.sv
// Shared dimensions, types and FSM encodings for the IRU output scheduler.
package iru_pkg;

   localparam int unsigned IRU_DIM    = 20;
   localparam int unsigned IRU_LANES  = 5;
   localparam int unsigned IRU_PIXELS = 400;

   typedef logic [7:0] iru_pix_t;
   typedef logic [4:0] iru_coord_t;
   typedef logic [1:0] iru_sched_state_e;

   localparam iru_sched_state_e StFill  = 2'd0;
   localparam iru_sched_state_e StDrain = 2'd1;
   localparam iru_sched_state_e StFull  = 2'd2;
   localparam iru_sched_state_e StClear = 2'd3;

   // Raster index into the frame mask; caller guarantees row/col are in range.
   function automatic logic [8:0] pix_index(iru_coord_t row, iru_coord_t col);
      return 9'(row) * 9'(IRU_DIM) + 9'(col);
   endfunction

endpackage

// File: rtl/iru_out_sched_if.sv
// Lane write, buffer write and frame handshake bundle of the output scheduler.
interface iru_out_sched_if;
   import iru_pkg::*;

   logic       [IRU_LANES-1:0] ln_valid;
   logic       [IRU_LANES-1:0] ln_ready;
   iru_coord_t [IRU_LANES-1:0] ln_row;
   iru_coord_t [IRU_LANES-1:0] ln_col;
   iru_pix_t   [IRU_LANES-1:0] ln_d;

   logic       [IRU_LANES-1:0] buf_wr;
   iru_coord_t [IRU_LANES-1:0] buf_row;
   iru_coord_t [IRU_LANES-1:0] buf_col;
   iru_pix_t   [IRU_LANES-1:0] buf_d;
   logic                       buf_z;

   logic                       img_valid;
   logic                       img_ready;
   logic       [8:0]           pixel_cnt;
   logic                       err_oob;

   modport slave (
      input  ln_valid, ln_row, ln_col, ln_d, img_ready,
      output ln_ready, buf_wr, buf_row, buf_col, buf_d, buf_z, img_valid, pixel_cnt, err_oob
   );

   modport master (
      output ln_valid, ln_row, ln_col, ln_d, img_ready,
      input  ln_ready, buf_wr, buf_row, buf_col, buf_d, buf_z, img_valid, pixel_cnt, err_oob
   );

endinterface

// File: rtl/iru_collide_arb.sv
// Same-address collision resolver: rotating priority among valid in-range lanes.
module iru_collide_arb
   import iru_pkg::*;
(
   input  logic       [IRU_LANES-1:0] valid,
   input  iru_coord_t [IRU_LANES-1:0] row,
   input  iru_coord_t [IRU_LANES-1:0] col,
   input  logic       [2:0]           prio_ptr,
   output logic       [IRU_LANES-1:0] win,
   output logic       [IRU_LANES-1:0] oob,
   output logic                       collide
);

   logic [IRU_LANES-1:0] in_rng;
   logic [IRU_LANES-1:0] lose;
   logic [2:0]           rank [IRU_LANES];

   always_comb begin
      lose = '0;
      for (int i = 0; i < IRU_LANES; i++) begin
         in_rng[i] = valid[i] && (row[i] < 5'(IRU_DIM)) && (col[i] < 5'(IRU_DIM));
         oob[i]    = valid[i] && !in_rng[i];
         // Distance from prio_ptr going upward mod 5; smaller rank wins.
         rank[i]   = (3'(i) >= prio_ptr) ? 3'(i) - prio_ptr
                                         : 3'(i) + 3'(IRU_LANES) - prio_ptr;
      end
      for (int i = 0; i < IRU_LANES; i++) begin
         for (int j = i + 1; j < IRU_LANES; j++) begin
            if (in_rng[i] && in_rng[j] && (row[i] == row[j]) && (col[i] == col[j])) begin
               if (rank[i] < rank[j]) lose[j] = 1'b1;
               else                   lose[i] = 1'b1;
            end
         end
      end
      win     = valid & ~lose;
      collide = |lose;
   end

endmodule

// File: rtl/iru_out_sched.sv
// Output buffer write scheduler: lane arbitration, frame mask/count and FILL/DRAIN/FULL/CLEAR.
module iru_out_sched
   import iru_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            abort,
   iru_out_sched_if.slave  bus
);

   iru_sched_state_e           state_q, state_d;
   logic [2:0]                 prio_q, prio_d;
   logic [IRU_PIXELS-1:0]      mask_q, mask_d;
   logic [8:0]                 cnt_q, cnt_d;
   logic [8:0]                 idx;
   logic [IRU_LANES-1:0]       win, oob, acc, wr;
   logic                       collide, fill;
   logic [IRU_LANES-1:0]       buf_wr_q;
   iru_coord_t [IRU_LANES-1:0] buf_row_q, buf_col_q;
   iru_pix_t   [IRU_LANES-1:0] buf_d_q;
   logic                       err_oob_q;

   iru_collide_arb u_arb (
      .valid    (bus.ln_valid),
      .row      (bus.ln_row),
      .col      (bus.ln_col),
      .prio_ptr (prio_q),
      .win      (win),
      .oob      (oob),
      .collide  (collide)
   );

   // rst_n gates ready so no lane sees a handshake while the block is held in reset.
   assign fill = rst_n && (state_q == StFill) && !abort;
   assign acc  = fill ? win : '0;
   assign wr   = acc & ~oob;

   assign prio_d = (fill && collide) ? ((prio_q == 3'd4) ? 3'd0 : prio_q + 3'd1) : prio_q;

   always_comb begin
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      idx     = '0;
      state_d = state_q;
      for (int i = 0; i < IRU_LANES; i++) begin
         if (wr[i]) begin
            idx = pix_index(bus.ln_row[i], bus.ln_col[i]);
            if (!mask_d[idx]) cnt_d = cnt_d + 9'd1;
            mask_d[idx] = 1'b1;
         end
      end
      case (state_q)
         StFill:  if (cnt_d == 9'(IRU_PIXELS)) state_d = StDrain;
         StDrain: state_d = StFull;
         StFull:  if (bus.img_ready) state_d = StClear;
         default: state_d = StFill;
      endcase
      if (abort) state_d = StClear;
      if (state_q == StClear) begin
         mask_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFill;
         prio_q    <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         buf_wr_q  <= '0;
         buf_row_q <= '0;
         buf_col_q <= '0;
         buf_d_q   <= '0;
         err_oob_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         buf_wr_q  <= wr;
         err_oob_q <= |(acc & oob);
         for (int i = 0; i < IRU_LANES; i++) begin
            if (acc[i]) begin
               buf_row_q[i] <= bus.ln_row[i];
               buf_col_q[i] <= bus.ln_col[i];
               buf_d_q[i]   <= bus.ln_d[i];
            end
         end
      end
   end

   assign bus.ln_ready  = acc;
   assign bus.buf_wr    = buf_wr_q;
   assign bus.buf_row   = buf_row_q;
   assign bus.buf_col   = buf_col_q;
   assign bus.buf_d     = buf_d_q;
   assign bus.buf_z     = (state_q == StClear);
   assign bus.img_valid = (state_q == StFull);
   assign bus.pixel_cnt = cnt_q;
   assign bus.err_oob   = err_oob_q;

endmodule

// File: doc/iru_out_sched.md
# iru_out_sched

Write scheduler and frame sequencer for the IRU output buffer (20×20 bytes, 5 write ports, synchronous clear `z`). It accepts pixel writes from five rotation lanes over valid/ready handshakes and resolves same-address collisions with rotating priority, so the buffer never sees contention. It tracks frame completion with a 400-bit written mask, presents the finished frame to the downstream consumer, then clears the buffer for the next frame.

## Interface
- No parameters; dimensions come from `iru_pkg`.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `abort`  in  1  synchronous frame abort
- `ln_valid[4:0]`  in  5  lane write request
- `ln_ready[4:0]`  out  5  lane write accepted this cycle
- `ln_row[4:0]`, `ln_col[4:0]`  in  5×5  target coordinate per lane
- `ln_d[4:0]`  in  5×8  pixel data per lane
- `buf_wr[4:0]`  out  5  buffer write enables (registered)
- `buf_row`, `buf_col`  out  5×5  buffer coordinates (registered)
- `buf_d`  out  5×8  buffer data (registered)
- `buf_z`  out  1  buffer clear, one-cycle pulse
- `img_valid`  out  1  frame complete and readable from buffer
- `img_ready`  in  1  consumer done with frame
- `pixel_cnt`  out  9  distinct pixels written, 0..400
- `err_oob`  out  1  one-cycle pulse: an out-of-range write was dropped

## Operation
- FSM states: FILL, DRAIN, FULL, CLEAR. Reset state: FILL.
- FILL: `ln_ready[i]` = `ln_valid[i]` and not a collision loser and not `abort`. Accepting a write loads the registered `buf_*` slot i.
- Collision: two or more valid, in-range lanes with an identical (row, col). Priority order is `prio_ptr`, `prio_ptr+1`, … mod 5. Only the highest-priority lane is ready; the losers stall.
- `prio_ptr` (3 bits, reset 0) increments mod 5 at the end of any cycle that had at least one collision stall.
- Out of range (row ≥ 20 or col ≥ 20): the lane is accepted but not written (`buf_wr[i]`=0), and `err_oob` pulses on the next cycle. It does not take part in collision checks.
- Mask: an accepted in-range write sets `mask[row*20+col]`. `pixel_cnt` increments only on 0→1 mask transitions. Multiple new bits in one cycle add their popcount.
- A duplicate write to an already-set pixel is still issued to the buffer (overwrite), with no count change.
- FILL→DRAIN: when the next-state count equals 400.
- DRAIN→FULL: unconditional after 1 cycle. Lanes are not ready in DRAIN, FULL or CLEAR.
- FULL: `img_valid`=1. On `img_ready`=1 → CLEAR. `img_ready` is ignored in other states.
- CLEAR: `buf_z`=1 for exactly one cycle; mask, `pixel_cnt` and `buf_wr` are cleared. → FILL.
- `abort`: from any state, go to CLEAR next cycle. Writes presented in the abort cycle are not accepted. `abort` wins over a simultaneous final accept or `img_ready`.

## Timing
- Reset values: `ln_ready`=0 while in reset, `buf_wr`=0, `buf_row`/`buf_col`/`buf_d`=0, `buf_z`=0, `img_valid`=0, `pixel_cnt`=0, `err_oob`=0, state FILL, `prio_ptr`=0.
- `ln_ready` is combinational from `ln_valid`, coordinates, state, `abort` and `prio_ptr`.
- Write latency: accept in cycle N → `buf_wr` high in N+1 → data in buffer after the N+1 edge.
- Frame latency: final accept in N → DRAIN in N+1 → `img_valid` from N+2.
- `img_ready` in M → CLEAR (`buf_z`=1) in M+1 → FILL with `ln_ready` possible in M+2.
- Peak throughput: 5 pixels/cycle. Minimum frame period: 80 fill cycles + DRAIN + FULL handshake + CLEAR.

## Structure
- `iru_pkg`: `IRU_DIM`=20, `IRU_LANES`=5, `IRU_PIXELS`=400, `iru_pix_t` (8-bit), `iru_coord_t` (5-bit), `iru_sched_state_e`.
- Sub-module `iru_collide_arb`: combinational. Inputs are valid, coordinates and `prio_ptr`. Outputs are the winner mask, the collision flag and the oob mask (10 pairwise comparators plus a rotate).
- The top level holds the FSM, mask, popcount/counter and output registers.

## Test plan
- Reset, then idle → `ln_ready` follows `ln_valid`; `buf_wr`=0, `buf_z`=0, `img_valid`=0, `pixel_cnt`=0.
- Lanes 0 and 3 both target (5,7) with `prio_ptr`=0 → `ln_ready`=5'b00001; next cycle `buf_wr`=5'b00001 and `prio_ptr`=1; lane 3 is accepted that cycle.
- 400 distinct pixels, 5/cycle for 80 cycles → `img_valid` 2 cycles after the last accept; `img_ready` pulse → `buf_z` high for 1 cycle, then FILL with `pixel_cnt`=0.
- Lane 2 writes row 20, col 3 → accepted; next cycle `buf_wr[2]`=0, `err_oob`=1; `pixel_cnt` unchanged.
- Pixel (0,0) written twice in separate cycles → `buf_wr` asserted both times; `pixel_cnt` rises by 1.
- `abort` at `pixel_cnt`=123 with lanes valid → `ln_ready`=0 that cycle; next cycle `buf_z`=1; then `pixel_cnt`=0 and FILL.
